drc_lookup_arbiter: RTL

Arbitrates between host cache requests and ECC scrubber requests for the single DRC tag-lookup pipeline. Holds one registered issue slot that feeds the tag-array read and the tag comparator stage. Host has fixed priority, with an ECC starvation guard. A read-after-write index hazard window protects the tag-array update latency.

---
 rtl/drc_pkg.sv | 19 +
 rtl/drc_arb_hazard_tracker.sv | 42 ++++
 rtl/drc_lookup_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/drc_pkg.sv
// Shared types and widths for the DRC tag-lookup arbiter and its hazard tracker.
package drc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    ECC  = 2'd2
  } state_t;

  localparam int DATA_W = 272;
  localparam int SYN_W  = 32;
  localparam int ERR_W  = 8;

  // Width needed to hold the value n (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/drc_arb_hazard_tracker.sv
// Read-after-write index hazard window: blocks one set index for HAZARD_CYC
// cycles after a host write is accepted into the lookup slot.
module drc_arb_hazard_tracker
  import drc_pkg::*;
#(
  parameter int IDX_SIZE   = 4,
  parameter int HAZARD_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [IDX_SIZE-1:0] i_load_index,
  input  logic [IDX_SIZE-1:0] i_host_index,
  input  logic [IDX_SIZE-1:0] i_ecc_index,
  output logic                o_host_blk,
  output logic                o_ecc_blk
);

  localparam int HZ_W = cnt_width(HAZARD_CYC);

  logic [IDX_SIZE-1:0] r_hz_index;
  logic [HZ_W-1:0]     r_hz_cnt;
  logic                w_active;

  // A fresh write reloads the window even while an older one is still draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hz_index <= '0;
      r_hz_cnt   <= '0;
    end else if (i_load && (HAZARD_CYC > 0)) begin
      r_hz_index <= i_load_index;
      r_hz_cnt   <= HZ_W'(HAZARD_CYC);
    end else if (r_hz_cnt != '0) begin
      r_hz_cnt <= r_hz_cnt - 1'b1;
    end
  end

  assign w_active   = (r_hz_cnt != '0);
  assign o_host_blk = w_active && (i_host_index == r_hz_index);
  assign o_ecc_blk  = w_active && (i_ecc_index == r_hz_index);

endmodule

// File: rtl/drc_lookup_arbiter.sv
// Host/ECC-scrubber arbiter feeding the single DRC tag-lookup issue slot.
// Optional DRC_ARB_PERF_CNT_EN adds grant and hazard-stall counters.
module drc_lookup_arbiter
  import drc_pkg::*;
#(
  parameter int TAG_SIZE     = 20,
  parameter int IDX_SIZE     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4,
  parameter int HAZARD_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef DRC_ARB_PERF_CNT_EN
  input  logic                perf_clr_i,
  output logic [31:0]         perf_host_gnt_o,
  output logic [31:0]         perf_ecc_gnt_o,
  output logic [31:0]         perf_hz_stall_o,
`endif
  input  logic                host_valid_i,
  output logic                host_ready_o,
  input  logic                host_we_i,
  input  logic [TAG_SIZE-1:0] host_tag_i,
  input  logic [IDX_SIZE-1:0] host_index_i,
  input  logic [DATA_W-1:0]   host_data_i,
  input  logic                ecc_valid_i,
  output logic                ecc_ready_o,
  input  logic [TAG_SIZE-1:0] ecc_tag_i,
  input  logic [IDX_SIZE-1:0] ecc_index_i,
  input  logic [DATA_W-1:0]   ecc_data_i,
  input  logic [SYN_W-1:0]    ecc_syndrome_i,
  input  logic [ERR_W-1:0]    ecc_err_i,
  input  logic                pipe_ready_i,
  output logic                tagrd_en_o,
  output logic [TAG_SIZE-1:0] tag_o,
  output logic [IDX_SIZE-1:0] index_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [SYN_W-1:0]    syndrome_o,
  output logic [ERR_W-1:0]    err_o,
  output logic                host_valid_o,
  output logic                host_we_o,
  output logic                ecc_valid_o
);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic [TAG_SIZE-1:0] r_tag;
  logic [IDX_SIZE-1:0] r_index;
  logic [DATA_W-1:0]   r_data;
  logic [SYN_W-1:0]    r_syndrome;
  logic [ERR_W-1:0]    r_err;
  logic                r_host_we;

  logic w_consume, w_load_ok;
  logic w_host_blk, w_ecc_blk;
  logic w_host_elig, w_ecc_elig;
  logic w_starved;
  logic w_gnt_host, w_gnt_ecc;

  drc_arb_hazard_tracker #(
    .IDX_SIZE   (IDX_SIZE),
    .HAZARD_CYC (HAZARD_CYC)
  ) u_hazard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_gnt_host && host_we_i),
    .i_load_index (host_index_i),
    .i_host_index (host_index_i),
    .i_ecc_index  (ecc_index_i),
    .o_host_blk   (w_host_blk),
    .o_ecc_blk    (w_ecc_blk)
  );

  assign w_consume   = (r_state != IDLE) && pipe_ready_i;
  assign w_load_ok   = (r_state == IDLE) || w_consume;
  assign w_host_elig = host_valid_i && !w_host_blk;
  assign w_ecc_elig  = ecc_valid_i && !w_ecc_blk;
  assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Host has fixed priority unless the scrubber has hit its starvation limit.
  assign w_gnt_host = w_load_ok && w_host_elig && !(w_ecc_elig && w_starved);
  assign w_gnt_ecc  = w_load_ok && w_ecc_elig && !w_gnt_host;

  always_comb begin
    w_state_next = r_state;
    if (w_gnt_host)     w_state_next = HOST;
    else if (w_gnt_ecc) w_state_next = ECC;
    else if (w_consume) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= '0;
      r_index    <= '0;
      r_data     <= '0;
      r_syndrome <= '0;
      r_err      <= '0;
      r_host_we  <= 1'b0;
    end else if (w_gnt_host) begin
      r_tag      <= host_tag_i;
      r_index    <= host_index_i;
      r_data     <= host_data_i;
      r_syndrome <= '0;
      r_err      <= '0;
      r_host_we  <= host_we_i;
    end else if (w_gnt_ecc) begin
      r_tag      <= ecc_tag_i;
      r_index    <= ecc_index_i;
      r_data     <= ecc_data_i;
      r_syndrome <= ecc_syndrome_i;
      r_err      <= ecc_err_i;
      r_host_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (ecc_valid_i && !w_gnt_ecc) begin
      if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

`ifdef DRC_ARB_PERF_CNT_EN
  logic [31:0] r_perf_host, r_perf_ecc, r_perf_hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_host <= '0;
      r_perf_ecc  <= '0;
      r_perf_hz   <= '0;
    end else if (perf_clr_i) begin
      r_perf_host <= '0;
      r_perf_ecc  <= '0;
      r_perf_hz   <= '0;
    end else begin
      if (w_gnt_host) r_perf_host <= r_perf_host + 32'd1;
      if (w_gnt_ecc)  r_perf_ecc  <= r_perf_ecc + 32'd1;
      if ((host_valid_i && w_host_blk) || (ecc_valid_i && w_ecc_blk))
        r_perf_hz <= r_perf_hz + 32'd1;
    end
  end

  assign perf_host_gnt_o = r_perf_host;
  assign perf_ecc_gnt_o  = r_perf_ecc;
  assign perf_hz_stall_o = r_perf_hz;
`endif

  assign host_ready_o = w_gnt_host;
  assign ecc_ready_o  = w_gnt_ecc;
  assign tagrd_en_o   = w_consume;
  assign tag_o        = r_tag;
  assign index_o      = r_index;
  assign data_o       = r_data;
  assign syndrome_o   = r_syndrome;
  assign err_o        = r_err;
  assign host_we_o    = r_host_we;
  assign host_valid_o = (r_state == HOST);
  assign ecc_valid_o  = (r_state == ECC);

endmodule
